// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and constants for the serial pattern transmitter
package seq_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b11,
    DONE = 2'b10
  } state_t;
  localparam logic [3:0] SEQ_1101 = 4'b1101;
endpackage

// File: rtl/seq_tx.sv
// seq_tx: Moore FSM that serialises a latched pattern MSB first, repeated with idle gaps
module seq_tx
  import seq_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  input  logic [CNT_W-1:0] gap,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);
  localparam int BW = $clog2(PAT_W);
  localparam logic [BW-1:0] LAST = BW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state, state_n;
  logic [PAT_W-1:0] sh, sh_n, pat_l, pat_l_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic [CNT_W-1:0] rep_cnt, rep_cnt_n, gap_cnt, gap_cnt_n, gap_l, gap_l_n;
  // state and datapath registers; reset overrides start and abort
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sh      <= '0;
      pat_l   <= '0;
      bit_cnt <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
      gap_l   <= '0;
    end else begin
      state   <= state_n;
      sh      <= sh_n;
      pat_l   <= pat_l_n;
      bit_cnt <= bit_cnt_n;
      rep_cnt <= rep_cnt_n;
      gap_cnt <= gap_cnt_n;
      gap_l   <= gap_l_n;
    end
  end
  // next state plus shift register and counter updates; rep_cnt holds repetitions still to send
  always_comb begin
    state_n   = state;
    sh_n      = sh;
    pat_l_n   = pat_l;
    bit_cnt_n = bit_cnt;
    rep_cnt_n = rep_cnt;
    gap_cnt_n = gap_cnt;
    gap_l_n   = gap_l;
    unique case (state)
      IDLE: if (start) begin
        pat_l_n   = pattern;
        sh_n      = pattern;
        rep_cnt_n = reps;
        gap_l_n   = gap;
        bit_cnt_n = '0;
        state_n   = (reps != '0) ? SEND : DONE;
      end
      SEND: if (abort) state_n = IDLE;
      else if (bit_cnt == LAST) begin
        rep_cnt_n = rep_cnt - ONE;
        bit_cnt_n = '0;
        sh_n      = pat_l;
        gap_cnt_n = gap_l;
        state_n   = (rep_cnt == ONE) ? DONE : (gap_l != '0) ? GAP : SEND;
      end else begin
        sh_n      = sh << 1;
        bit_cnt_n = bit_cnt + 1'b1;
      end
      GAP: if (abort) state_n = IDLE;
      else begin
        gap_cnt_n = gap_cnt - ONE;
        state_n   = (gap_cnt == ONE) ? SEND : GAP;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Moore outputs decoded from registered state only
  always_comb begin
    out       = (state == SEND) ? sh[PAT_W-1] : 1'b0;
    out_valid = (state == SEND);
    busy      = (state == SEND) || (state == GAP);
    done      = (state == DONE);
  end
endmodule

// File: tb/tb_seq_tx.sv
// tb_seq_tx: directed self-checking bench for seq_tx
module tb_seq_tx;
  import seq_pkg::*;
  logic clk = 1'b0;
  logic rst, start, abort;
  logic [3:0] pattern, reps, gap;
  logic out, out_valid, busy, done;
  int n_cmp = 0;
  int n_bad = 0;
  seq_tx #(.PAT_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pattern(pattern), .reps(reps), .gap(gap),
    .out(out), .out_valid(out_valid), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // observed word is {out, out_valid, busy, done}: send bit b = {b,1,1,0}, gap = 2, done = 1, idle = 0
  task automatic step(input string tag, input logic [3:0] e);
    chk(tag, {28'd0, out, out_valid, busy, done}, {28'd0, e});
    tick();
  endtask
  task automatic launch(input logic [3:0] p, input logic [3:0] r, input logic [3:0] g);
    pattern = p;
    reps = r;
    gap = g;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  // expected cycles packed left to right as hex digits, first digit is cycle 1
  task automatic run(input string tag, input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) step($sformatf("%s[%0d]", tag, i + 1), v[4*(n-1-i) +: 4]);
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    pattern = '0;
    reps = '0;
    gap = '0;
    tick();
    start = 1'b1;
    abort = 1'b1;
    tick();
    step("reset", 4'h0);
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    launch(SEQ_1101, 4'd1, 4'd0);
    run("single", 128'hEE6E10, 6);
    launch(SEQ_1101, 4'd3, 4'd2);
    run("gap", 128'hEE6E22EE6E22EE6E10, 18);
    launch(SEQ_1101, 4'd2, 4'd0);
    run("b2b", 128'hEE6EEE6E10, 10);
    launch(SEQ_1101, 4'd0, 4'd0);
    run("zero", 128'h100, 3);
    launch(4'b0110, 4'd2, 4'd1);
    run("pat0110", 128'h6EE626EE610, 11);
    launch(SEQ_1101, 4'd3, 4'd0);
    step("abort[1]", 4'hE);
    start = 1'b1;
    pattern = 4'b0000;
    reps = 4'd0;
    step("abort[2]", 4'hE);
    start = 1'b0;
    abort = 1'b1;
    step("abort[3]", 4'h6);
    abort = 1'b0;
    step("abort[4]", 4'h0);
    pattern = SEQ_1101;
    reps = 4'd1;
    gap = 4'd0;
    start = 1'b1;
    abort = 1'b1;
    step("abort[5]", 4'h0);
    start = 1'b0;
    abort = 1'b0;
    run("restart", 128'hEE6E10, 6);
    launch(SEQ_1101, 4'd3, 4'd2);
    run("pre_rst", 128'hEE6E, 4);
    rst = 1'b1;
    step("pre_rst[5]", 4'h2);
    rst = 1'b0;
    step("post_rst[6]", 4'h0);
    step("post_rst[7]", 4'h0);
    launch(4'b1010, 4'd1, 4'd0);
    run("after_rst", 128'hE6E610, 6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_tx.md
SEQ_TX -- requirements
Module: seq_tx

Interface
REQ-001 Parameter PAT_W, default 4, pattern length in bits (legal range 2..16).
REQ-002 Parameter CNT_W, default 4, width of the repetition and gap count inputs.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  request to begin a transmission; acted on only in IDLE.
REQ-006 abort  input  1  synchronous cancel of a transmission in progress.
REQ-007 pattern  input  PAT_W  bit pattern to send, MSB first; sampled only on an accepted start.
REQ-008 reps  input  CNT_W  number of pattern repetitions; sampled only on an accepted start.
REQ-009 gap  input  CNT_W  number of idle cycles between repetitions; sampled only on an accepted start.
REQ-010 out  output  1  serial data bit.
REQ-011 out_valid  output  1  out carries a pattern bit this cycle.
REQ-012 busy  output  1  transmission in progress (SEND or GAP).
REQ-013 done  output  1  single-cycle pulse marking normal completion.

Function
REQ-014 The block SHALL be a Moore FSM: all outputs are functions of registered state only.
REQ-015 The FSM SHALL have states IDLE, SEND, GAP and DONE.
  - IDLE: out=0, out_valid=0, busy=0, done=0.
  - SEND: out=shift-register MSB, out_valid=1, busy=1.
  - GAP: out=0, out_valid=0, busy=1.
  - DONE: done=1, busy=0, all other outputs 0.
REQ-016 Start acceptance SHALL be: IDLE and start=1 at edge N latches pattern, reps and gap; reps!=0 enters SEND, so the first bit (pattern[PAT_W-1]) appears in cycle N+1.
REQ-017 With reps=0, an accepted start SHALL go IDLE->DONE with no valid bits.
REQ-018 SEND SHALL emit exactly PAT_W consecutive bits per repetition, MSB first, one per cycle.
REQ-019 After the last bit of a repetition, the next state SHALL be:
  - DONE, if it was the final repetition;
  - GAP, if gap!=0;
  - SEND (back-to-back, no bubble), if gap=0.
  - The shift register reloads the latched pattern for the next repetition.
REQ-020 GAP SHALL last exactly gap cycles, then return to SEND.
REQ-021 DONE SHALL last exactly one cycle, then go to IDLE.
REQ-022 start SHALL be ignored in SEND, GAP and DONE; changes to pattern, reps or gap after acceptance SHALL have no effect.
REQ-023 abort=1 in SEND or GAP SHALL move to IDLE at that edge with no done pulse; abort in IDLE or DONE SHALL be ignored.
REQ-024 abort and start asserted together in IDLE: start wins.
REQ-025 Counters SHALL be sized as follows: bit counter ceil(log2(PAT_W)) bits, repetition and gap counters CNT_W bits; no counter wraps.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE and clear shift register, counters and all outputs to 0, overriding start and abort.
REQ-027 Reset mid-transmission SHALL truncate output immediately, with no done pulse.

Structure
REQ-028 Shared package seq_pkg SHALL hold:
  - the state type with Gray encoding IDLE=2'b00, SEND=2'b01, GAP=2'b11, DONE=2'b10;
  - constant SEQ_1101 = 4'b1101, the default pattern.
REQ-029 No sub-module is required; shift register and counters are inline, with one combinational next-state block and one sequential state block.

Verification
REQ-030 Single repetition: pattern=1101, reps=1, gap=0, start at edge 0 -> out 1,1,0,1 with out_valid=1 in cycles 1-4; done=1 in cycle 5; busy=1 in cycles 1-4 only.
REQ-031 Repetitions with gap: pattern=1101, reps=3, gap=2 -> 1101,00,1101,00,1101 over cycles 1-16; out_valid=0 in cycles 5-6 and 11-12; done in cycle 17.
REQ-032 Back-to-back: reps=2, gap=0 -> 8 contiguous valid cycles carrying 11011101; done in cycle 9.
REQ-033 Zero repetitions: reps=0, start -> out_valid never high; done in cycle 1; IDLE in cycle 2.
REQ-034 Abort and ignored start: pattern=1101, reps=3; start re-pulsed in cycle 2 is ignored; abort at edge 3 -> IDLE in cycle 4, no done; a new start at edge 5 sends a fresh 1101 from cycle 6.
REQ-035 Reset mid-gap: rst asserted at edge 5 of the REQ-031 case -> all outputs 0 from cycle 6; start is accepted again after rst deasserts.
